// File: rtl/pipe_regs_pkg.sv
// rtl/pipe_regs_pkg.sv - shared codes and bubble-record values for the pipeline registers
//
// Purpose: status codes, instruction codes, register ID constants and the
//          field values a stage register takes when it is bubbled.
// Ports:   none (package).

package pipe_regs_pkg;

  typedef enum logic [2:0] {
    SBUB = 3'h0,
    SAOK = 3'h1,
    SHLT = 3'h2,
    SADR = 3'h3,
    SINS = 3'h4
  } stat_e;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  // Non-value fields of a bubble record; every val* field of a bubble is zero.
  localparam logic [2:0] BUB_STAT  = SBUB;
  localparam logic [3:0] BUB_ICODE = INOP;
  localparam logic [3:0] BUB_IFUN  = 4'h0;
  localparam logic [3:0] BUB_REG   = RNONE;
  localparam logic       BUB_CND   = 1'b0;

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - one generic pipeline stage register with stall and bubble
//
// Purpose: holds on stall, loads BUB_VAL on bubble, otherwise loads d.
//          Stall has priority over bubble. Reset forces RST_VAL without a clock.
// Ports:   clk, rst (async, active-high), stall, bubble, d [W-1:0] in;
//          q [W-1:0] out.

module pipe_stage_reg #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter logic [W-1:0] BUB_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (stall) begin
      q <= q;
    end else if (bubble) begin
      q <= BUB_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_regs.sv
// rtl/pipe_regs.sv - F/D/E/M/W pipeline registers with stall/bubble control
//
// Purpose: five stage registers between the pipeline stages. F holds the
//          predicted PC (stall only), D takes stall and bubble, E and M take
//          bubble only, W takes stall only. ctrl_err latches a request to
//          stall and bubble D on the same edge.
// Ports:   clk, rst (async, active-high); F_stall, D_stall, D_bubble,
//          E_bubble, M_bubble, W_stall; f_*/d_*/e_*/m_* stage results in;
//          F_predPC, D_*, E_*, M_*, W_* registered out; ctrl_err out;
//          stall_cnt, bubble_cnt out only when PIPE_REGS_CNT_EN is defined.
// Config:  PIPE_REGS_CNT_EN - adds saturating stall/bubble edge counters.

module pipe_regs
  import pipe_regs_pkg::*;
#(
  parameter int                RESET_PC_W = 64,
  parameter logic [63:0]       RESET_PC   = 64'h0,
  parameter int                WORD_W     = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              F_stall,
  input  logic              D_stall,
  input  logic              D_bubble,
  input  logic              E_bubble,
  input  logic              M_bubble,
  input  logic              W_stall,
  input  logic [WORD_W-1:0] f_predPC,
  output logic [WORD_W-1:0] F_predPC,
  input  logic [2:0]        f_stat,
  input  logic [3:0]        f_icode,
  input  logic [3:0]        f_ifun,
  input  logic [3:0]        f_rA,
  input  logic [3:0]        f_rB,
  input  logic [WORD_W-1:0] f_valC,
  input  logic [WORD_W-1:0] f_valP,
  output logic [2:0]        D_stat,
  output logic [3:0]        D_icode,
  output logic [3:0]        D_ifun,
  output logic [3:0]        D_rA,
  output logic [3:0]        D_rB,
  output logic [WORD_W-1:0] D_valC,
  output logic [WORD_W-1:0] D_valP,
  input  logic [2:0]        d_stat,
  input  logic [3:0]        d_icode,
  input  logic [3:0]        d_ifun,
  input  logic [WORD_W-1:0] d_valC,
  input  logic [WORD_W-1:0] d_valA,
  input  logic [WORD_W-1:0] d_valB,
  input  logic [3:0]        d_dstE,
  input  logic [3:0]        d_dstM,
  input  logic [3:0]        d_srcA,
  input  logic [3:0]        d_srcB,
  output logic [2:0]        E_stat,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [WORD_W-1:0] E_valC,
  output logic [WORD_W-1:0] E_valA,
  output logic [WORD_W-1:0] E_valB,
  output logic [3:0]        E_dstE,
  output logic [3:0]        E_dstM,
  output logic [3:0]        E_srcA,
  output logic [3:0]        E_srcB,
  input  logic [2:0]        e_stat,
  input  logic [3:0]        e_icode,
  input  logic              e_Cnd,
  input  logic [WORD_W-1:0] e_valE,
  input  logic [WORD_W-1:0] e_valA,
  input  logic [3:0]        e_dstE,
  input  logic [3:0]        e_dstM,
  output logic [2:0]        M_stat,
  output logic [3:0]        M_icode,
  output logic              M_Cnd,
  output logic [WORD_W-1:0] M_valE,
  output logic [WORD_W-1:0] M_valA,
  output logic [3:0]        M_dstE,
  output logic [3:0]        M_dstM,
  input  logic [2:0]        m_stat,
  input  logic [3:0]        m_icode,
  input  logic [WORD_W-1:0] m_valE,
  input  logic [WORD_W-1:0] m_valM,
  input  logic [3:0]        m_dstE,
  input  logic [3:0]        m_dstM,
  output logic [2:0]        W_stat,
  output logic [3:0]        W_icode,
  output logic [WORD_W-1:0] W_valE,
  output logic [WORD_W-1:0] W_valM,
  output logic [3:0]        W_dstE,
  output logic [3:0]        W_dstM,
  output logic              ctrl_err
`ifdef PIPE_REGS_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  localparam int D_W  = 19 + 2 * WORD_W;
  localparam int E_W  = 27 + 3 * WORD_W;
  localparam int M_W  = 16 + 2 * WORD_W;
  localparam int WB_W = 15 + 2 * WORD_W;

  localparam logic [D_W-1:0] D_BUB = {BUB_STAT, BUB_ICODE, BUB_IFUN, BUB_REG, BUB_REG,
                                      {(2 * WORD_W){1'b0}}};
  localparam logic [E_W-1:0] E_BUB = {BUB_STAT, BUB_ICODE, BUB_IFUN, {(3 * WORD_W){1'b0}},
                                      BUB_REG, BUB_REG, BUB_REG, BUB_REG};
  localparam logic [M_W-1:0] M_BUB = {BUB_STAT, BUB_ICODE, BUB_CND, {(2 * WORD_W){1'b0}},
                                      BUB_REG, BUB_REG};
  localparam logic [WB_W-1:0] W_BUB = {BUB_STAT, BUB_ICODE, {(2 * WORD_W){1'b0}},
                                       BUB_REG, BUB_REG};

  logic [D_W-1:0]  dreg_d, dreg_q;
  logic [E_W-1:0]  ereg_d, ereg_q;
  logic [M_W-1:0]  mreg_d, mreg_q;
  logic [WB_W-1:0] wreg_d, wreg_q;

  assign dreg_d = {f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP};
  assign ereg_d = {d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
                   d_dstE, d_dstM, d_srcA, d_srcB};
  assign mreg_d = {e_stat, e_icode, e_Cnd, e_valE, e_valA, e_dstE, e_dstM};
  assign wreg_d = {m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM};

  assign {D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP} = dreg_q;
  assign {E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
          E_dstE, E_dstM, E_srcA, E_srcB} = ereg_q;
  assign {M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM} = mreg_q;
  assign {W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM} = wreg_q;

  // F never bubbles; its reset value is the boot PC.
  pipe_stage_reg #(
    .W(WORD_W), .RST_VAL(RESET_PC[WORD_W-1:0]), .BUB_VAL('0)
  ) u_f (
    .clk(clk), .rst(rst), .stall(F_stall), .bubble(1'b0), .d(f_predPC), .q(F_predPC)
  );

  pipe_stage_reg #(.W(D_W), .RST_VAL(D_BUB), .BUB_VAL(D_BUB)) u_d (
    .clk(clk), .rst(rst), .stall(D_stall), .bubble(D_bubble), .d(dreg_d), .q(dreg_q)
  );

  pipe_stage_reg #(.W(E_W), .RST_VAL(E_BUB), .BUB_VAL(E_BUB)) u_e (
    .clk(clk), .rst(rst), .stall(1'b0), .bubble(E_bubble), .d(ereg_d), .q(ereg_q)
  );

  pipe_stage_reg #(.W(M_W), .RST_VAL(M_BUB), .BUB_VAL(M_BUB)) u_m (
    .clk(clk), .rst(rst), .stall(1'b0), .bubble(M_bubble), .d(mreg_d), .q(mreg_q)
  );

  // W never bubbles; a held W stays held for as long as W_stall is high.
  pipe_stage_reg #(.W(WB_W), .RST_VAL(W_BUB), .BUB_VAL(W_BUB)) u_w (
    .clk(clk), .rst(rst), .stall(W_stall), .bubble(1'b0), .d(wreg_d), .q(wreg_q)
  );

  // Sticky until reset: control logic asked D to both hold and flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_err <= 1'b0;
    end else if (D_stall && D_bubble) begin
      ctrl_err <= 1'b1;
    end
  end

`ifdef PIPE_REGS_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= 32'h0;
      bubble_cnt <= 32'h0;
    end else begin
      if ((F_stall || D_stall || W_stall) && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'h1;
      end
      if ((D_bubble || E_bubble || M_bubble) && (bubble_cnt != 32'hFFFF_FFFF)) begin
        bubble_cnt <= bubble_cnt + 32'h1;
      end
    end
  end
`endif

endmodule
